// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 keyboard transmitter: the TX FSM state
// encoding, the frame length, the scancode prefix bytes, and a helper that
// returns one bit of an 11-bit device-to-host frame.
// ---------------------------------------------------------------------------
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_BIT_HI,
        ST_BIT_LO,
        ST_GAP
    } tx_state_e;

    // Start bit, eight data bits, odd parity bit and stop bit.
    localparam int FRAME_BITS = 11;

    localparam logic [7:0] PREFIX_EXT   = 8'hE0;  // extended-key prefix
    localparam logic [7:0] PREFIX_BREAK = 8'hF0;  // key-release prefix

    // Frame bit idx of a byte: 0 = start, 1..8 = data LSB first,
    // 9 = odd parity, 10 = stop.
    function automatic logic frame_bit(input logic [7:0] data, input logic [3:0] idx);
        logic b;
        b = 1'b1;
        if (idx == 4'd0) begin
            b = 1'b0;
        end else if (idx <= 4'd8) begin
            b = data[3'(idx - 4'd1)];
        end else if (idx == 4'd9) begin
            b = ~^data;
        end
        return b;
    endfunction

endpackage

// File: rtl/ps2_byte_fifo.sv
// ---------------------------------------------------------------------------
// ps2_byte_fifo
// Byte FIFO that accepts up to three bytes per cycle (one whole key event)
// and releases one byte per cycle. The writer is responsible for checking
// free space; this block never refuses a push.
//
// Ports
//   clk_sys     system clock
//   reset       asynchronous active-high reset (empties the FIFO)
//   push        write push_num bytes this cycle
//   push_num    number of bytes to write (1..3)
//   push_bytes  bytes to write, first byte in [7:0]
//   pop         remove the head byte this cycle
//   pop_data    head byte (valid while empty is low)
//   count       current occupancy
//   empty       occupancy is zero
// ---------------------------------------------------------------------------
module ps2_byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk_sys,
    input  logic                     reset,
    input  logic                     push,
    input  logic [1:0]               push_num,
    input  logic [23:0]              push_bytes,
    input  logic                     pop,
    output logic [7:0]               pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    mem_q [DEPTH];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        // NOTE: every signal assigned in a combinational block gets a default
        // first, so no path leaves it unassigned and no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(push_num);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + (push ? CW'(push_num) : CW'(0)) - (pop ? CW'(1) : CW'(0));
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        // NOTE: clocked state is updated with non-blocking assignments so every
        // flop samples the pre-edge values regardless of statement order.
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array has no reset; the pointers and count define
    // which entries are meaningful, so stale contents are never observed.
    always_ff @(posedge clk_sys) begin
        if (push) begin
            for (int i = 0; i < 3; i++) begin
                if (i < int'(push_num)) begin
                    mem_q[wr_ptr_q + AW'(i)] <= push_bytes[8*i +: 8];
                end
            end
        end
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign count    = count_q;
    assign empty    = (count_q == '0);

endmodule

// File: rtl/ps2_key_tx.sv
// ---------------------------------------------------------------------------
// ps2_key_tx
// Turns toggle-flagged key events into PS/2 set-2 scancode bytes and
// transmits them, device-to-host, on a PS/2 clock/data pair driven towards a
// keyboard-controller core.
//
// Parameters
//   HALF_DIV    clk_sys cycles per PS/2 clock half-period
//   FIFO_DEPTH  byte FIFO depth (power of two, >= 4)
//   GAP_HALVES  minimum idle half-periods between frames
//
// Ports
//   clk_sys           system clock
//   reset             asynchronous active-high reset
//   ps2_key           [10] toggle, [9] pressed, [8] extended, [7:0] scancode
//   ps2_clk_in        sensed PS/2 clock line (low = host inhibit)
//   ps2_kbd_clk_out   PS/2 clock to the core, 1 = released
//   ps2_kbd_data_out  PS/2 data to the core, 1 = released
//   busy              FIFO non-empty or a frame/gap in progress
//   overflow          one-cycle pulse when an event is dropped
// ---------------------------------------------------------------------------
module ps2_key_tx
    import ps2_pkg::*;
#(
    parameter int HALF_DIV   = 1200,
    parameter int FIFO_DEPTH = 16,
    parameter int GAP_HALVES = 4
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [10:0] ps2_key,
    input  logic        ps2_clk_in,
    output logic        ps2_kbd_clk_out,
    output logic        ps2_kbd_data_out,
    output logic        busy,
    output logic        overflow
);

    localparam int GAP_CYC = GAP_HALVES * HALF_DIV;
    localparam int CNT_W   = $clog2(GAP_CYC + 1);
    localparam int CW      = $clog2(FIFO_DEPTH) + 1;

    // ---------------- event encoder ----------------
    logic          prime_q, prime_d;
    logic          prev_toggle_q, prev_toggle_d;
    logic          overflow_q, overflow_d;
    logic          evt;
    logic          accept;
    logic [1:0]    enc_num;
    logic [23:0]   enc_bytes;
    logic [CW-1:0] free_after_pop;

    // ---------------- FIFO ----------------
    logic          pop;
    logic [7:0]    fifo_data;
    logic [CW-1:0] fifo_count;
    logic          fifo_empty;

    // ---------------- TX FSM ----------------
    tx_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    tx_byte_q, tx_byte_d;

    always_comb begin
        prime_d       = 1'b1;
        prev_toggle_d = ps2_key[10];
        // The first cycle after reset only captures the toggle level.
        evt = prime_q && (ps2_key[10] != prev_toggle_q);

        // Byte order on the wire: [E0] [F0] scancode.
        case ({ps2_key[8], ps2_key[9]})
            2'b00:   begin enc_num = 2'd2; enc_bytes = {8'h00, ps2_key[7:0], PREFIX_BREAK}; end
            2'b01:   begin enc_num = 2'd1; enc_bytes = {16'h0000, ps2_key[7:0]}; end
            2'b10:   begin enc_num = 2'd3; enc_bytes = {ps2_key[7:0], PREFIX_BREAK, PREFIX_EXT}; end
            default: begin enc_num = 2'd2; enc_bytes = {8'h00, ps2_key[7:0], PREFIX_EXT}; end
        endcase

        // A byte leaving this cycle frees its slot for the incoming event.
        free_after_pop = CW'(FIFO_DEPTH) - fifo_count + (pop ? CW'(1) : CW'(0));
        accept         = evt && (free_after_pop >= CW'(enc_num));
        overflow_d     = evt && !accept;
    end

    ps2_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .push       (accept),
        .push_num   (enc_num),
        .push_bytes (enc_bytes),
        .pop        (pop),
        .pop_data   (fifo_data),
        .count      (fifo_count),
        .empty      (fifo_empty)
    );

    // ---------------- state register ----------------
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            bit_idx_q     <= '0;
            tx_byte_q     <= '0;
            prime_q       <= 1'b0;
            prev_toggle_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bit_idx_q     <= bit_idx_d;
            tx_byte_q     <= tx_byte_d;
            prime_q       <= prime_d;
            prev_toggle_q <= prev_toggle_d;
            overflow_q    <= overflow_d;
        end
    end

    // ---------------- next-state logic ----------------
    // The half-period counter reloads on entry to every timed state and the
    // state advances on the cycle it reads zero.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        tx_byte_d = tx_byte_q;
        pop       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    tx_byte_d = fifo_data;
                    state_d   = ST_CHECK;
                end
            end
            ST_CHECK: begin
                // Host inhibit is honoured only here; a started frame completes.
                if (ps2_clk_in) begin
                    state_d   = ST_BIT_HI;
                    bit_idx_d = '0;
                    cnt_d     = CNT_W'(HALF_DIV - 1);
                end
            end
            ST_BIT_HI: begin
                if (cnt_q == '0) begin
                    state_d = ST_BIT_LO;
                    cnt_d   = CNT_W'(HALF_DIV - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_BIT_LO: begin
                if (cnt_q == '0) begin
                    if (bit_idx_q == 4'(FRAME_BITS - 1)) begin
                        state_d = ST_GAP;
                        cnt_d   = CNT_W'(GAP_CYC - 1);
                    end else begin
                        state_d   = ST_BIT_HI;
                        bit_idx_d = bit_idx_q + 1'b1;
                        cnt_d     = CNT_W'(HALF_DIV - 1);
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- outputs ----------------
    // The bit index only advances on entry to BIT_HI, so data is stable for
    // the whole low phase and the core's falling-edge sample is clean.
    always_comb begin
        ps2_kbd_clk_out  = 1'b1;
        ps2_kbd_data_out = 1'b1;
        case (state_q)
            ST_BIT_HI: ps2_kbd_data_out = frame_bit(tx_byte_q, bit_idx_q);
            ST_BIT_LO: begin
                ps2_kbd_clk_out  = 1'b0;
                ps2_kbd_data_out = frame_bit(tx_byte_q, bit_idx_q);
            end
            default: ;
        endcase
        busy = !fifo_empty || (state_q != ST_IDLE);
    end

    assign overflow = overflow_q;

endmodule

// File: tb/tb_ps2_key_tx.sv
// ---------------------------------------------------------------------------
// tb_ps2_key_tx
// Directed key events feed an expected-byte queue; an independent monitor
// decodes frames from the PS/2 lines and compares each against the queue,
// along with clock low-phase length, data stability and inter-frame gap.
// ---------------------------------------------------------------------------
module tb_ps2_key_tx;

    localparam int HALF    = 20;
    localparam int GAP_H   = 4;
    localparam int DEPTH   = 16;
    localparam int GAP_CYC = GAP_H * HALF;

    typedef struct {
        logic [7:0] data;
        logic       par;
    } exp_t;

    logic        clk_sys = 1'b0;
    logic        reset   = 1'b1;
    logic [10:0] ps2_key = '0;
    logic        ps2_clk_in = 1'b1;
    logic        ps2_kbd_clk_out;
    logic        ps2_kbd_data_out;
    logic        busy;
    logic        overflow;

    int   checks = 0;
    int   fails  = 0;
    exp_t exp_q[$];
    logic tog = 1'b0;

    // monitor state
    int          mon_bits = 0;
    int          low_cnt  = 0;
    int          gap_cnt  = 0;
    int          frames_seen = 0;
    logic        gap_armed  = 1'b0;
    logic        prev_clk   = 1'b1;
    logic        fall_data  = 1'b1;
    logic        data_moved = 1'b0;
    logic [10:0] frame_v    = '0;
    logic [10:0] last_frame = '0;

    logic [7:0] fill_code [8] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33};
    logic       fill_par  [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    always #5 clk_sys = ~clk_sys;

    ps2_key_tx #(
        .HALF_DIV   (HALF),
        .FIFO_DEPTH (DEPTH),
        .GAP_HALVES (GAP_H)
    ) dut (
        .clk_sys          (clk_sys),
        .reset            (reset),
        .ps2_key          (ps2_key),
        .ps2_clk_in       (ps2_clk_in),
        .ps2_kbd_clk_out  (ps2_kbd_clk_out),
        .ps2_kbd_data_out (ps2_kbd_data_out),
        .busy             (busy),
        .overflow         (overflow)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [7:0] d, input logic p);
        exp_t e;
        e.data = d;
        e.par  = p;
        exp_q.push_back(e);
    endtask

    // Present one toggle event on a falling edge and check the overflow pulse.
    task automatic send_key(input logic ext, input logic pressed, input logic [7:0] code,
                            input logic exp_ovf, input string tag);
        @(negedge clk_sys);
        tog = ~tog;
        ps2_key = {tog, pressed, ext, code};
        @(posedge clk_sys);
        #1;
        check({tag, "_ovf"}, overflow, exp_ovf);
        if (exp_ovf) begin
            @(posedge clk_sys);
            #1;
            check({tag, "_ovf_clr"}, overflow, 1'b0);
        end
    endtask

    task automatic wait_sb_empty(input int budget, input string tag);
        for (int c = 0; c < budget && exp_q.size() != 0; c++) @(negedge clk_sys);
        check({tag, "_drained"}, exp_q.size(), 0);
    endtask

    task automatic wait_idle(input int budget, input string tag);
        for (int c = 0; c < budget && busy; c++) @(negedge clk_sys);
        check({tag, "_idle"}, busy, 1'b0);
    endtask

    // Returns on the falling edge just before the IDLE cycle that pops the
    // next byte: GAP starts when the clock rises after the 11th low phase.
    task automatic wait_pop_slot(input string tag);
        int   falls;
        logic found;
        logic pc;
        falls = 0;
        found = 1'b0;
        pc    = ps2_kbd_clk_out;
        for (int c = 0; c < 2000 && !found; c++) begin
            @(negedge clk_sys);
            if (pc && !ps2_kbd_clk_out) falls++;
            if (!pc && ps2_kbd_clk_out && falls == 11) found = 1'b1;
            pc = ps2_kbd_clk_out;
        end
        check({tag, "_gap_seen"}, found, 1'b1);
        repeat (GAP_CYC - 1) @(negedge clk_sys);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk_sys) begin
        if (reset) begin
            mon_bits   = 0;
            low_cnt    = 0;
            gap_armed  = 1'b0;
            data_moved = 1'b0;
            prev_clk   = 1'b1;
        end else begin
            if (prev_clk && !ps2_kbd_clk_out) begin
                frame_v    = {ps2_kbd_data_out, frame_v[10:1]};
                mon_bits++;
                low_cnt    = 1;
                fall_data  = ps2_kbd_data_out;
                data_moved = 1'b0;
            end else if (!prev_clk && !ps2_kbd_clk_out) begin
                low_cnt++;
                if (ps2_kbd_data_out != fall_data) data_moved = 1'b1;
            end else if (!prev_clk && ps2_kbd_clk_out) begin
                check("clk_low_len", low_cnt, HALF);
                check("data_stable_low", data_moved, 1'b0);
                if (mon_bits >= 11) begin
                    frames_seen++;
                    last_frame = frame_v;
                    check("start_bit", frame_v[0], 1'b0);
                    check("stop_bit", frame_v[10], 1'b1);
                    check("frame_expected", exp_q.size() != 0, 1'b1);
                    if (exp_q.size() != 0) begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check("frame_byte", frame_v[8:1], e.data);
                        check("frame_parity", frame_v[9], e.par);
                    end
                    mon_bits  = 0;
                    gap_armed = 1'b1;
                    gap_cnt   = 0;
                end
            end
            if (gap_armed) begin
                if (ps2_kbd_clk_out && ps2_kbd_data_out) begin
                    gap_cnt++;
                end else begin
                    check("gap_len_ok", gap_cnt >= GAP_CYC, 1'b1);
                    gap_armed = 1'b0;
                end
            end
            prev_clk = ps2_kbd_clk_out;
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        repeat (60000) @(posedge clk_sys);
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic any_low;
        logic started;
        logic found;
        int   saved;

        repeat (3) @(negedge clk_sys);
        check("rst_clk", ps2_kbd_clk_out, 1'b1);
        check("rst_data", ps2_kbd_data_out, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_ovf", overflow, 1'b0);
        reset = 1'b0;
        repeat (3) @(negedge clk_sys);
        check("post_rst_busy", busy, 1'b0);

        // Make of 0x1C: single byte, bits 0,0,0,1,1,1,0,0,0,0,1.
        push_exp(8'h1C, 1'b0);
        send_key(1'b0, 1'b1, 8'h1C, 1'b0, "make_1c");
        check("make_busy", busy, 1'b1);
        wait_sb_empty(2000, "make_1c");
        check("make_frame_bits", last_frame, 11'h438);
        wait_idle(500, "make_1c");

        // Release of extended 0x74: E0, F0, 74.
        push_exp(8'hE0, 1'b0);
        push_exp(8'hF0, 1'b1);
        push_exp(8'h74, 1'b1);
        send_key(1'b1, 1'b0, 8'h74, 1'b0, "brk_e074");
        wait_sb_empty(5000, "brk_e074");
        wait_idle(500, "brk_e074");

        // Fill under host inhibit: eight 2-byte events, a rejected 3-byte
        // event, then a 1-byte event that exactly fills the FIFO.
        ps2_clk_in = 1'b0;
        for (int i = 0; i < 8; i++) begin
            push_exp(8'hF0, 1'b1);
            push_exp(fill_code[i], fill_par[i]);
            send_key(1'b0, 1'b0, fill_code[i], 1'b0, "fill");
        end
        send_key(1'b1, 1'b0, 8'h11, 1'b1, "fill_ext3");
        push_exp(8'h45, 1'b0);
        send_key(1'b0, 1'b1, 8'h45, 1'b0, "fill_last");

        any_low = 1'b0;
        repeat (500) begin
            @(negedge clk_sys);
            if (!ps2_kbd_clk_out || !ps2_kbd_data_out) any_low = 1'b1;
        end
        check("inhibit_hold_high", any_low, 1'b0);
        check("inhibit_busy", busy, 1'b1);

        @(negedge clk_sys);
        ps2_clk_in = 1'b1;
        started = 1'b0;
        repeat (2) begin
            @(negedge clk_sys);
            if (!ps2_kbd_data_out) started = 1'b1;
        end
        check("release_start", started, 1'b1);

        // Full FIFO, event in the pop cycle: one free slot after the pop.
        wait_pop_slot("pop1");
        push_exp(8'h16, 1'b0);
        send_key(1'b0, 1'b1, 8'h16, 1'b0, "pop_accept");
        // Full again: a 2-byte event does not fit even with the pop.
        wait_pop_slot("pop2");
        send_key(1'b0, 1'b0, 8'h1E, 1'b1, "pop_reject");
        wait_sb_empty(15000, "fill");
        wait_idle(500, "fill");

        // Reset in the middle of a frame with another byte queued.
        push_exp(8'h1C, 1'b0);
        send_key(1'b0, 1'b1, 8'h1C, 1'b0, "mid_a");
        push_exp(8'h2B, 1'b1);
        send_key(1'b0, 1'b1, 8'h2B, 1'b0, "mid_b");
        found = 1'b0;
        for (int c = 0; c < 2000 && !found; c++) begin
            @(negedge clk_sys);
            if (mon_bits >= 6) found = 1'b1;
        end
        check("mid_bit5_reached", found, 1'b1);
        check("mid_clk_low", ps2_kbd_clk_out, 1'b0);
        reset = 1'b1;
        #1;
        check("mid_rst_clk", ps2_kbd_clk_out, 1'b1);
        check("mid_rst_data", ps2_kbd_data_out, 1'b1);
        check("mid_rst_busy", busy, 1'b0);
        exp_q.delete();
        saved = frames_seen;
        repeat (3) @(negedge clk_sys);
        reset = 1'b0;
        any_low = 1'b0;
        repeat (1000) begin
            @(negedge clk_sys);
            if (!ps2_kbd_clk_out || !ps2_kbd_data_out || busy) any_low = 1'b1;
        end
        check("post_mid_quiet", any_low, 1'b0);
        check("post_mid_frames", frames_seen, saved);
        check("final_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
